motor_speed_loop: RTL and testbench
===================================

MOTOR_SPEED_LOOP -- requirements
Module: motor_speed_loop

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 50000, sys_clk cycles per control sample.
REQ-002 SHALL have parameter GAIN_SHIFT, default 4, arithmetic right shift applied to the summed PI term.
REQ-003 SHALL have parameter INTEG_MAX, default 65535, symmetric clamp magnitude of the integrator.
REQ-004 SHALL have port sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port pos  input  32  encoder position count, already in the sys_clk domain.
REQ-007 SHALL have port target  input  16  signed target velocity, counts per sample.
REQ-008 SHALL have port kp, ki  input  8 each  unsigned proportional and integral gains.
REQ-009 SHALL have port loop_en  input  1  closed-loop enable.
REQ-010 SHALL have port pwm_cmp  output  8  duty compare value to the PWM stage.
REQ-011 SHALL have port dir  output  1  direction, 1 = negative drive.
REQ-012 SHALL have port en  output  1  motor enable to the PWM stage.
REQ-013 SHALL have port vel  output  16  signed measured velocity of the last sample.
REQ-014 SHALL have port sat  output  1  high while the last output was clamped.
REQ-015 SHALL have port done  output  1  one-cycle pulse when outputs update.

Function
REQ-016 SHALL count 0..SAMPLE_DIV-1 with a free-running timer and raise an internal tick at the wrap.
REQ-017 SHALL sequence FSM IDLE -> SAMPLE -> ERROR -> MULT -> SUM -> UPDATE -> IDLE, one cycle per state, leaving IDLE only on tick.
REQ-018 SHALL, in SAMPLE, compute delta = pos - prev_pos modulo 2^32, saturate it to signed 16 bits into vel, and load prev_pos <= pos.
REQ-019 SHALL, in ERROR, compute err = target - vel at 17 bits and saturate it to signed 16.
REQ-020 SHALL, in MULT, compute p = kp*err and integ_next = clamp(integ + err, ±INTEG_MAX), followed by i = ki*integ_next, all sign-correct.
REQ-021 SHALL, in SUM, compute u = (p + i) >>> GAIN_SHIFT and clamp u to ±255; sat = 1 iff the clamp engaged.
REQ-022 SHALL, in UPDATE, drive dir = (u < 0), pwm_cmp = |u|, en = loop_en & (u != 0), and pulse done; registered outputs change exactly 5 cycles after tick.
REQ-023 SHALL commit integ <= integ_next only when loop_en is high and sat is low (anti-windup); otherwise SHALL hold integ.
REQ-024 SHALL, while loop_en is low, hold integ at 0, drive en = 0 and pwm_cmp = 0 at UPDATE, and still track prev_pos and vel.
REQ-025 SHALL, on a loop_en falling edge, force en = 0 and pwm_cmp = 0 on the next cycle regardless of FSM state.
REQ-026 SHALL ignore a tick arriving outside IDLE; this cannot happen with SAMPLE_DIV >= 6, the minimum legal value.
REQ-027 SHALL treat pos wrap-around from 0xFFFFFFFF to 0x00000000 as delta = +1.

Reset
REQ-028 SHALL, on sys_rst_n low, clear timer, FSM (to IDLE), prev_pos, integ, pwm_cmp, dir, en, vel, sat and done to 0.
REQ-029 SHALL take the first sample after reset release relative to prev_pos = 0; the first vel therefore equals pos (saturated), which is accepted behaviour.
REQ-030 SHALL abandon any in-flight computation on reset mid-sequence, with no output update.

Structure
REQ-031 SHALL take widths (POS_W = 32, VEL_W = 16, CMP_W = 8) and FSM state encoding from shared package motor_pkg.
REQ-032 SHALL use one sub-module, motor_sat, a parameterised signed saturate-to-N-bits helper instanced for vel, err and u.
REQ-033 SHALL use exactly one 8x16 and one 8x17 signed multiplier; no DSP sharing across instances.

Verification
REQ-034 SHALL check: SAMPLE_DIV = 10, loop_en = 0, pos stepped +7 per sample -> vel = 7, en = 0, pwm_cmp = 0, done every 10 cycles.
REQ-035 SHALL check: kp = 16, ki = 0, target = 20, constant pos -> u = 20, pwm_cmp = 20, dir = 0, en = 1, 5 cycles after tick.
REQ-036 SHALL check: kp = 16, target = -100, constant pos -> pwm_cmp = 100 and dir = 1; with kp = 64 -> pwm_cmp = 255 and sat = 1.
REQ-037 SHALL check: ki = 16, kp = 0, target = 1, constant pos -> pwm_cmp rises by 1 per sample and freezes at 255 with sat = 1, integ not growing.
REQ-038 SHALL check: pos 0xFFFFFFFE -> 0x00000003 across one sample -> vel = 5; with a jump of 0x00100000 -> vel = 32767.
REQ-039 SHALL check: sys_rst_n pulsed low during MULT -> all outputs 0 immediately, no done pulse, next done at 5 cycles after the first post-reset tick.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared widths and FSM encoding for the motor speed control loop.
package motor_pkg;

    localparam int POS_W   = 32;
    localparam int VEL_W   = 16;
    localparam int CMP_W   = 8;
    localparam int INTEG_W = 17;
    localparam int P_W     = 25;  // 9-bit zero-extended gain times 16-bit error
    localparam int I_W     = 26;  // 9-bit zero-extended gain times 17-bit integrator
    localparam int ACC_W   = 27;
    localparam int U_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_ERROR  = 3'd2,
        ST_MULT   = 3'd3,
        ST_SUM    = 3'd4,
        ST_UPDATE = 3'd5
    } state_t;

endpackage

// File: rtl/motor_sat.sv
// Signed saturation from IN_W to OUT_W bits; SYMMETRIC drops the most
// negative code so the range is +/-(2^(OUT_W-1)-1).
module motor_sat #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter bit SYMMETRIC = 1'b0
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clamped
);

    localparam logic signed [IN_W-1:0] HI = $signed({{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [IN_W-1:0] LO = SYMMETRIC ? -HI : ~HI;

    always_comb begin
        clamped = 1'b0;
        dout    = din[OUT_W-1:0];
        if (din > HI) begin
            dout    = HI[OUT_W-1:0];
            clamped = 1'b1;
        end else if (din < LO) begin
            dout    = LO[OUT_W-1:0];
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/motor_speed_loop.sv
// Sampled PI speed loop: measures encoder velocity every SAMPLE_DIV cycles and
// produces a PWM duty/direction command five cycles after each sample tick.
module motor_speed_loop
    import motor_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int GAIN_SHIFT = 4,
    parameter int INTEG_MAX  = 65535
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [POS_W-1:0]  pos,
    input  logic [VEL_W-1:0]  target,
    input  logic [7:0]        kp,
    input  logic [7:0]        ki,
    input  logic              loop_en,
    output logic [CMP_W-1:0]  pwm_cmp,
    output logic              dir,
    output logic              en,
    output logic [VEL_W-1:0]  vel,
    output logic              sat,
    output logic              done
);

    localparam int TMR_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int ISUM_W = INTEG_W + 1;
    localparam logic [TMR_W-1:0]         TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
    localparam logic signed [ISUM_W-1:0] IMAX     = ISUM_W'(INTEG_MAX);
    localparam logic signed [ISUM_W-1:0] IMIN     = -IMAX;

    logic [TMR_W-1:0] timer;
    logic             tick;
    state_t           state_q, state_d;
    logic             ld_vel, ld_err, ld_mult, ld_out;

    logic [POS_W-1:0]          prev_pos;
    logic signed [POS_W-1:0]   delta;
    logic signed [VEL_W-1:0]   vel_next;
    logic signed [VEL_W:0]     err_wide;
    logic signed [VEL_W-1:0]   err_next, err_q;
    logic signed [INTEG_W-1:0] integ, integ_next_c, integ_next_q;
    logic signed [ISUM_W-1:0]  integ_sum;
    logic signed [P_W-1:0]     p_next, p_q;
    logic signed [I_W-1:0]     i_next, i_q;
    logic signed [ACC_W-1:0]   acc, u_sh;
    logic signed [U_W-1:0]     u;
    logic [U_W-1:0]            u_neg;
    logic [CMP_W-1:0]          u_abs;
    logic                      u_clamped;
    logic                      unused_vel_clamp, unused_err_clamp;

    assign tick = (timer == TMR_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer   <= '0;
            state_q <= ST_IDLE;
        end else begin
            timer   <= tick ? '0 : timer + TMR_W'(1);
            state_q <= state_d;
        end
    end

    // Ticks outside IDLE are dropped; SAMPLE_DIV >= 6 guarantees none occur.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_ERROR;
            ST_ERROR:  state_d = ST_MULT;
            ST_MULT:   state_d = ST_SUM;
            ST_SUM:    state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_vel  = 1'b0;
        ld_err  = 1'b0;
        ld_mult = 1'b0;
        ld_out  = 1'b0;
        case (state_q)
            ST_SAMPLE: ld_vel  = 1'b1;
            ST_ERROR:  ld_err  = 1'b1;
            ST_MULT:   ld_mult = 1'b1;
            ST_SUM:    ld_out  = 1'b1;
            default:   ;
        endcase
    end

    assign delta    = $signed(pos - prev_pos);
    assign err_wide = $signed({target[VEL_W-1], target}) - $signed({vel[VEL_W-1], vel});
    assign p_next   = P_W'($signed({1'b0, kp})) * P_W'(err_q);
    assign integ_sum = ISUM_W'(integ) + ISUM_W'(err_q);

    always_comb begin
        integ_next_c = integ_sum[INTEG_W-1:0];
        if (integ_sum > IMAX)
            integ_next_c = IMAX[INTEG_W-1:0];
        else if (integ_sum < IMIN)
            integ_next_c = IMIN[INTEG_W-1:0];
    end

    assign i_next = I_W'($signed({1'b0, ki})) * I_W'(integ_next_c);
    assign acc    = ACC_W'(p_q) + ACC_W'(i_q);
    assign u_sh   = acc >>> GAIN_SHIFT;
    assign u_neg  = U_W'(-u);
    assign u_abs  = u[U_W-1] ? u_neg[CMP_W-1:0] : u[CMP_W-1:0];

    motor_sat #(.IN_W(POS_W), .OUT_W(VEL_W), .SYMMETRIC(1'b0)) u_sat_vel (
        .din(delta), .dout(vel_next), .clamped(unused_vel_clamp)
    );
    motor_sat #(.IN_W(VEL_W + 1), .OUT_W(VEL_W), .SYMMETRIC(1'b0)) u_sat_err (
        .din(err_wide), .dout(err_next), .clamped(unused_err_clamp)
    );
    motor_sat #(.IN_W(ACC_W), .OUT_W(U_W), .SYMMETRIC(1'b1)) u_sat_u (
        .din(u_sh), .dout(u), .clamped(u_clamped)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_pos     <= '0;
            vel          <= '0;
            err_q        <= '0;
            p_q          <= '0;
            i_q          <= '0;
            integ_next_q <= '0;
        end else begin
            if (ld_vel) begin
                vel      <= vel_next;
                prev_pos <= pos;
            end
            if (ld_err)
                err_q <= err_next;
            if (ld_mult) begin
                p_q          <= p_next;
                i_q          <= i_next;
                integ_next_q <= integ_next_c;
            end
        end
    end

    // Disabling the loop zeroes the drive within one cycle, whatever the FSM is doing.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            integ   <= '0;
            pwm_cmp <= '0;
            dir     <= 1'b0;
            en      <= 1'b0;
            sat     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= ld_out;
            if (ld_out) begin
                sat     <= u_clamped;
                dir     <= u[U_W-1];
                pwm_cmp <= u_abs;
                en      <= (u != '0);
            end
            if (!loop_en) begin
                integ   <= '0;
                pwm_cmp <= '0;
                en      <= 1'b0;
            end else if (ld_out && !u_clamped) begin
                integ <= integ_next_q;
            end
        end
    end

endmodule

// File: tb/tb_motor_speed_loop.sv
// Directed bench for motor_speed_loop with a per-sample reference model feeding
// an expected-result queue that is drained on every done pulse.
module tb_motor_speed_loop;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] pos = '0;
    logic [15:0] target = '0;
    logic [7:0]  kp = '0;
    logic [7:0]  ki = '0;
    logic        loop_en = 1'b0;
    logic [7:0]  pwm_cmp;
    logic        dir;
    logic        en;
    logic [15:0] vel;
    logic        sat;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_prev = '0;
    int          m_integ = 0;
    logic [26:0] exp_q[$];

    motor_speed_loop #(.SAMPLE_DIV(10), .GAIN_SHIFT(4), .INTEG_MAX(65535)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pos(pos), .target(target),
        .kp(kp), .ki(ki), .loop_en(loop_en), .pwm_cmp(pwm_cmp), .dir(dir),
        .en(en), .vel(vel), .sat(sat), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int sat_int(input int x, input int hi, input int lo);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_push();
        logic [31:0] d;
        logic [26:0] ex;
        logic [7:0]  pwm8;
        int v, e, p, inext, i, s, u, au;
        bit satf;
        d = pos - m_prev;
        m_prev = pos;
        v = sat_int($signed(d), 32767, -32768);
        e = sat_int(int'($signed(target)) - v, 32767, -32768);
        if (!loop_en) m_integ = 0;
        p = int'(kp) * e;
        inext = sat_int(m_integ + e, 65535, -65535);
        i = int'(ki) * inext;
        s = (p + i) >>> 4;
        u = sat_int(s, 255, -255);
        satf = (u != s);
        if (loop_en && !satf) m_integ = inext;
        au = (u < 0) ? -u : u;
        pwm8 = loop_en ? au[7:0] : 8'd0;
        ex = {v[15:0], pwm8, (u < 0), (loop_en && u != 0), satf};
        exp_q.push_back(ex);
    endtask

    task automatic wait_done(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                n = k;
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    // Drive one sample's inputs, predict its outputs, then wait for done and compare.
    task automatic step(input logic [31:0] p, input logic [15:0] t, input logic [7:0] kpv,
                        input logic [7:0] kiv, input logic le, input int gap);
        logic [26:0] ex;
        int n;
        bit ok;
        pos = p;
        target = t;
        kp = kpv;
        ki = kiv;
        loop_en = le;
        model_push();
        wait_done(n, ok);
        if (gap != 0) chk("done_gap", 32'(n), 32'(gap));
        ex = exp_q.pop_front();
        if (ok) begin
            chk("vel", 32'(vel), 32'(ex[26:11]));
            chk("pwm_cmp", 32'(pwm_cmp), 32'(ex[10:3]));
            chk("dir", 32'(dir), 32'(ex[2]));
            chk("en", 32'(en), 32'(ex[1]));
            chk("sat", 32'(sat), 32'(ex[0]));
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_pwm", 32'(pwm_cmp), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_vel", 32'(vel), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        sys_rst_n = 1'b1;
        step(32'd0, 16'd0, 8'd0, 8'd0, 1'b0, 14);

        // Open loop: velocity tracked, drive held off.
        for (int k = 1; k <= 4; k++) begin
            step(32'(7 * k), 16'd0, 8'd16, 8'd0, 1'b0, 10);
            chk("open_vel7", 32'(vel), 32'd7);
            chk("open_pwm0", 32'(pwm_cmp), 32'd0);
        end

        // Proportional only, positive and negative targets, then saturation.
        repeat (2) step(32'd28, 16'd20, 8'd16, 8'd0, 1'b1, 10);
        chk("p_pwm20", 32'(pwm_cmp), 32'd20);
        chk("p_dir0", 32'(dir), 32'd0);
        chk("p_en1", 32'(en), 32'd1);
        repeat (2) step(32'd28, 16'hFF9C, 8'd16, 8'd0, 1'b1, 10);
        chk("p_pwm100", 32'(pwm_cmp), 32'd100);
        chk("p_dir1", 32'(dir), 32'd1);
        repeat (2) step(32'd28, 16'hFF9C, 8'd64, 8'd0, 1'b1, 10);
        chk("p_pwm255", 32'(pwm_cmp), 32'd255);
        chk("p_sat1", 32'(sat), 32'd1);

        // Dropping loop_en mid-idle kills the drive on the next edge.
        repeat (2) @(negedge sys_clk);
        loop_en = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("fall_en0", 32'(en), 32'd0);
        chk("fall_pwm0", 32'(pwm_cmp), 32'd0);
        step(32'd28, 16'd0, 8'd0, 8'd0, 1'b0, 0);

        // Encoder wrap and velocity saturation.
        step(32'hFFFF_FFFE, 16'd0, 8'd0, 8'd0, 1'b0, 10);
        step(32'h0000_0003, 16'd0, 8'd0, 8'd0, 1'b0, 10);
        chk("wrap_vel5", 32'(vel), 32'd5);
        step(32'h0010_0003, 16'd0, 8'd0, 8'd0, 1'b0, 10);
        chk("vel_pos_clamp", 32'(vel), 32'h7FFF);
        step(32'h0000_0000, 16'd0, 8'd0, 8'd0, 1'b0, 10);
        chk("vel_neg_clamp", 32'(vel), 32'h8000);

        // Integral ramp up to saturation with anti-windup.
        for (int n = 1; n <= 260; n++) begin
            step(32'd0, 16'd1, 8'd0, 8'd16, 1'b1, 10);
            if (n <= 255) chk("ramp_pwm", 32'(pwm_cmp), 32'(n));
        end
        chk("ramp_sat", 32'(sat), 32'd1);
        chk("ramp_pwm255", 32'(pwm_cmp), 32'd255);

        // Reset asserted while the FSM sits in MULT.
        repeat (8) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_pwm", 32'(pwm_cmp), 32'd0);
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_sat", 32'(sat), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_vel", 32'(vel), 32'd0);
        chk("midrst_dir", 32'(dir), 32'd0);
        repeat (3) @(negedge sys_clk);
        m_prev = '0;
        m_integ = 0;
        sys_rst_n = 1'b1;
        step(32'd0, 16'd1, 8'd0, 8'd16, 1'b1, 14);
        chk("postrst_pwm1", 32'(pwm_cmp), 32'd1);
        step(32'd0, 16'd1, 8'd0, 8'd16, 1'b1, 10);
        chk("postrst_pwm2", 32'(pwm_cmp), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
